// File: rtl/dsp_pkg.sv
// Shared constants for the DSP multiply-accumulate pipeline:
// OPMODE bit positions and default operand/accumulator widths.
package dsp_pkg;

    localparam int unsigned OP_PREADD  = 0;
    localparam int unsigned OP_PRESUB  = 1;
    localparam int unsigned OP_LOAD    = 2;
    localparam int unsigned OP_POSTSUB = 3;

    localparam int unsigned DEF_A_WIDTH   = 18;
    localparam int unsigned DEF_B_WIDTH   = 18;
    localparam int unsigned DEF_ACC_WIDTH = 48;

endpackage

// File: rtl/dsp_sat_addsub.sv
// Combinational signed add/subtract with overflow detection and optional
// clamp to the most positive / most negative representable value.
module dsp_sat_addsub #(
    parameter int unsigned WIDTH  = 48,
    parameter int unsigned SAT_EN = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             ovf
);

    logic [WIDTH-1:0] raw;

    always_comb begin
        raw = sub ? (a - b) : (a + b);
        // Overflow when the operands' effective signs agree but the result's sign differs.
        if (sub) begin
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
        end else begin
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
        end
        s = raw;
        if ((SAT_EN != 0) && ovf) begin
            s = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/dsp_macc_pipe.sv
// Three-stage signed pre-add / multiply / accumulate pipeline with grouped
// results, sticky group overflow and a single global stall enable.
module dsp_macc_pipe
    import dsp_pkg::*;
#(
    parameter int unsigned A_WIDTH   = DEF_A_WIDTH,
    parameter int unsigned B_WIDTH   = DEF_B_WIDTH,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int unsigned SAT_EN    = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [A_WIDTH-1:0]   A,
    input  logic [B_WIDTH-1:0]   B,
    input  logic [B_WIDTH-1:0]   D,
    input  logic [3:0]           OPMODE,
    input  logic                 LAST,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [ACC_WIDTH-1:0] P,
    output logic                 OVF
);

    localparam int unsigned BP_W = B_WIDTH + 1;
    localparam int unsigned M_W  = A_WIDTH + B_WIDTH + 1;

    if (ACC_WIDTH < A_WIDTH + B_WIDTH + 1) begin : g_width_check
        $error("dsp_macc_pipe: ACC_WIDTH must be at least A_WIDTH+B_WIDTH+1");
    end

    logic                        en;
    logic signed [A_WIDTH-1:0]   a_s;
    logic signed [B_WIDTH-1:0]   b_s;
    logic signed [B_WIDTH-1:0]   d_s;
    logic signed [BP_W-1:0]      bp;

    // Stage 1
    logic                        v1;
    logic signed [A_WIDTH-1:0]   a1;
    logic signed [BP_W-1:0]      bp1;
    logic                        load1, sub1, last1;
    // Stage 2
    logic                        v2;
    logic signed [M_W-1:0]       m2;
    logic                        load2, sub2, last2;
    // Stage 3 / accumulator
    logic [ACC_WIDTH-1:0]        acc;
    logic                        sticky;
    logic [ACC_WIDTH-1:0]        acc_in;
    logic [ACC_WIDTH-1:0]        m_ext;
    logic [ACC_WIDTH-1:0]        s;
    logic                        add_ovf;
    logic                        grp_ovf;
    logic [ACC_WIDTH-1:0]        p_q;
    logic                        ovf_q;
    logic                        out_valid_q;

    assign en        = !out_valid_q || OUT_READY;
    assign IN_READY  = en;
    assign OUT_VALID = out_valid_q;
    assign P         = p_q;
    assign OVF       = ovf_q;

    assign a_s = A;
    assign b_s = B;
    assign d_s = D;

    always_comb begin
        bp = BP_W'(b_s);
        if (OPMODE[OP_PREADD]) begin
            bp = OPMODE[OP_PRESUB] ? (BP_W'(d_s) - BP_W'(b_s)) : (BP_W'(d_s) + BP_W'(b_s));
        end
    end

    // Load beats start from zero so a lone load+LAST yields the single product.
    always_comb begin
        acc_in  = load2 ? '0 : acc;
        m_ext   = ACC_WIDTH'(m2);
        grp_ovf = (load2 ? 1'b0 : sticky) | add_ovf;
    end

    dsp_sat_addsub #(
        .WIDTH  (ACC_WIDTH),
        .SAT_EN (SAT_EN)
    ) u_addsub (
        .a   (acc_in),
        .b   (m_ext),
        .sub (sub2),
        .s   (s),
        .ovf (add_ovf)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            v1          <= 1'b0;
            a1          <= '0;
            bp1         <= '0;
            load1       <= 1'b0;
            sub1        <= 1'b0;
            last1       <= 1'b0;
            v2          <= 1'b0;
            m2          <= '0;
            load2       <= 1'b0;
            sub2        <= 1'b0;
            last2       <= 1'b0;
            acc         <= '0;
            sticky      <= 1'b0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            v1    <= IN_VALID;
            a1    <= a_s;
            bp1   <= bp;
            load1 <= OPMODE[OP_LOAD];
            sub1  <= OPMODE[OP_POSTSUB];
            last1 <= LAST;

            v2    <= v1;
            m2    <= M_W'(a1) * M_W'(bp1);
            load2 <= load1;
            sub2  <= sub1;
            last2 <= last1;

            if (v2) begin
                acc    <= s;
                sticky <= grp_ovf;
                if (last2) begin
                    p_q   <= s;
                    ovf_q <= grp_ovf;
                end
            end
            // With en high any held result is being consumed this edge.
            out_valid_q <= v2 && last2;
        end
    end

endmodule

// File: tb/tb_dsp_macc_pipe.sv
// Scoreboard bench for dsp_macc_pipe: default-width instance plus two narrow
// instances (saturating and wrapping) sharing a narrow stimulus stream.
module tb_dsp_macc_pipe;

    typedef struct {
        longint p;
        bit     ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] a = '0;
    logic [17:0] b = '0;
    logic [17:0] d = '0;
    logic [3:0]  opmode = '0;
    logic        last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [47:0] p;
    logic        ovf;

    logic        in_valid8 = 1'b0;
    logic        in_ready_sat, in_ready_wrap;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [7:0]  d8 = '0;
    logic [3:0]  opmode8 = '0;
    logic        last8 = 1'b0;
    logic        out_valid_sat, out_valid_wrap;
    logic [17:0] p_sat, p_wrap;
    logic        ovf_sat, ovf_wrap;

    int checks = 0;
    int fails  = 0;

    res_t q_main[$];
    res_t q_sat[$];
    res_t q_wrap[$];

    always #5 clk = ~clk;

    dsp_macc_pipe dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .D(d), .OPMODE(opmode), .LAST(last),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .P(p), .OVF(ovf)
    );

    dsp_macc_pipe #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(18), .SAT_EN(1)) dut_sat (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid8), .IN_READY(in_ready_sat),
        .A(a8), .B(b8), .D(d8), .OPMODE(opmode8), .LAST(last8),
        .OUT_VALID(out_valid_sat), .OUT_READY(1'b1), .P(p_sat), .OVF(ovf_sat)
    );

    dsp_macc_pipe #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(18), .SAT_EN(0)) dut_wrap (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid8), .IN_READY(in_ready_wrap),
        .A(a8), .B(b8), .D(d8), .OPMODE(opmode8), .LAST(last8),
        .OUT_VALID(out_valid_wrap), .OUT_READY(1'b1), .P(p_wrap), .OVF(ovf_wrap)
    );

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitors: every presented result is compared against the queue head
    // each cycle, so a held result is also checked for stability.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q_main.size() == 0) begin
                chk("main_unexpected_valid", 1, 0);
            end else begin
                chk("main_p", $signed(p), q_main[0].p);
                chk("main_ovf", longint'(ovf), longint'(q_main[0].ovf));
                if (out_ready) void'(q_main.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_sat) begin
            if (q_sat.size() == 0) begin
                chk("sat_unexpected_valid", 1, 0);
            end else begin
                chk("sat_p", $signed(p_sat), q_sat[0].p);
                chk("sat_ovf", longint'(ovf_sat), longint'(q_sat[0].ovf));
                void'(q_sat.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_wrap) begin
            if (q_wrap.size() == 0) begin
                chk("wrap_unexpected_valid", 1, 0);
            end else begin
                chk("wrap_p", $signed(p_wrap), q_wrap[0].p);
                chk("wrap_ovf", longint'(ovf_wrap), longint'(q_wrap[0].ovf));
                void'(q_wrap.pop_front());
            end
        end
    end

    task automatic expect_main(input longint pv, input bit ov);
        res_t r;
        r.p = pv;
        r.ovf = ov;
        q_main.push_back(r);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input longint av, input longint bv, input longint dv,
                        input logic [3:0] op, input logic lst);
        int n;
        a = 18'(av);
        b = 18'(bv);
        d = 18'(dv);
        opmode = op;
        last = lst;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 200) begin
                chk("send_ready_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send8(input longint av, input longint bv, input logic [3:0] op,
                         input logic lst);
        a8 = 8'(av);
        b8 = 8'(bv);
        opmode8 = op;
        last8 = lst;
        in_valid8 = 1'b1;
        @(negedge clk);
        chk("sat_in_ready", longint'(in_ready_sat), 1);
        chk("wrap_in_ready", longint'(in_ready_wrap), 1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_main.size() != 0 || q_sat.size() != 0 || q_wrap.size() != 0 || out_valid) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 500) begin
                chk("drain_timeout", longint'(q_main.size() + q_sat.size() + q_wrap.size()), 0);
                break;
            end
        end
    endtask

    initial begin
        res_t r;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_p", longint'(p), 0);
        chk("reset_ovf", longint'(ovf), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", longint'(in_ready), 1);
        @(posedge clk);
        #1;

        // Single load+LAST beats, plain and with pre-adder.
        expect_main(-15, 0);
        send(3, -5, 0, 4'b0100, 1);
        expect_main(42, 0);
        send(7, 4, 10, 4'b0111, 1);
        expect_main(98, 0);
        send(7, 4, 10, 4'b0101, 1);
        expect_main(-12, 0);
        send(3, 4, 0, 4'b1100, 1);
        drain();

        // Sum of squares 1..4, then groups continuing on the held accumulator.
        send(1, 1, 0, 4'b0100, 0);
        send(2, 2, 0, 4'b0000, 0);
        send(3, 3, 0, 4'b0000, 0);
        expect_main(30, 0);
        send(4, 4, 0, 4'b0000, 1);
        expect_main(40, 0);
        send(2, 5, 0, 4'b0000, 1);
        expect_main(30, 0);
        send(2, 5, 0, 4'b1000, 1);
        drain();

        // Back-to-back results under consumer stall.
        out_ready = 1'b0;
        fork
            begin
                expect_main(6, 0);
                send(2, 3, 0, 4'b0100, 1);
                expect_main(-20, 0);
                send(-4, 5, 0, 4'b0100, 1);
                expect_main(-700, 0);
                send(100, -7, 0, 4'b0100, 1);
                expect_main(-131071, 0);
                send(131071, -1, 0, 4'b0100, 1);
            end
            begin
                repeat (12) @(negedge clk);
                chk("stall_in_ready", longint'(in_ready), 0);
                chk("stall_out_valid", longint'(out_valid), 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-group discards the in-flight beats.
        send(5, 5, 0, 4'b0100, 0);
        send(5, 5, 0, 4'b0000, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_pulse", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        expect_main(4, 0);
        send(2, 2, 0, 4'b0100, 1);
        drain();

        // Narrow instances: 8 x 16384 exceeds the 18-bit range.
        r.p = 131071;  r.ovf = 1'b1; q_sat.push_back(r);
        r.p = -131072; r.ovf = 1'b1; q_wrap.push_back(r);
        for (int k = 0; k < 8; k++) begin
            send8(-128, -128, (k == 0) ? 4'b0100 : 4'b0000, k == 7);
        end
        // A following load group starts with a clean overflow flag.
        r.p = 9; r.ovf = 1'b0; q_sat.push_back(r); q_wrap.push_back(r);
        send8(3, 3, 4'b0100, 1);
        drain();

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "timeout");
    end

endmodule
